// File: rtl/mmul_seq_ctrl.sv
// Sequencing controller for C = A x B on DIMxDIM 8-bit matrices through a single shared MAC.
// Optional sticky accumulator-wrap flag (ovf port) is built when MMUL_SEQ_OVF_EN is defined.
module mmul_seq_ctrl #(
  parameter int DIM = 2,
  parameter int AW  = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  input  logic [7:0]    a_data,
  input  logic [7:0]    b_data,
  output logic          mac_clr,
  output logic          mac_en,
  output logic [7:0]    mac_a,
  output logic [7:0]    mac_b,
  input  logic [15:0]   mac_out,
  output logic [AW-1:0] c_addr,
  output logic [15:0]   c_data,
  output logic          c_valid,
  input  logic          c_ready
`ifdef MMUL_SEQ_OVF_EN
  ,
  output logic          ovf
`endif
);

  localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [IW-1:0] LAST  = IW'(DIM - 1);
  localparam logic [AW-1:0] DIM_A = AW'(DIM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] i_reg, i_next;
  logic [IW-1:0] j_reg, j_next;
  logic [IW-1:0] k_reg, k_next;
  logic          mac_en_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      i_reg      <= '0;
      j_reg      <= '0;
      k_reg      <= '0;
      mac_en_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      i_reg      <= i_next;
      j_reg      <= j_next;
      k_reg      <= k_next;
      // Memory read latency is one cycle, so the enable trails the address issue.
      mac_en_reg <= (state_reg == S_FEED);
    end
  end

  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    k_next     = k_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_CLEAR;
          i_next     = '0;
          j_next     = '0;
          k_next     = '0;
        end
      end
      S_CLEAR: begin
        state_next = S_FEED;
        k_next     = '0;
      end
      S_FEED: begin
        if (k_reg == LAST) begin
          state_next = S_DRAIN;
          k_next     = '0;
        end else begin
          k_next = k_reg + 1'b1;
        end
      end
      S_DRAIN: begin
        state_next = S_WRITE;
      end
      S_WRITE: begin
        if (c_ready) begin
          if (j_reg == LAST) begin
            j_next = '0;
            if (i_reg == LAST) begin
              i_next     = '0;
              state_next = S_DONE;
            end else begin
              i_next     = i_reg + 1'b1;
              state_next = S_CLEAR;
            end
          end else begin
            j_next     = j_reg + 1'b1;
            state_next = S_CLEAR;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_reg != S_IDLE);
  assign done    = (state_reg == S_DONE);
  assign mac_clr = (state_reg == S_CLEAR);
  assign mac_en  = mac_en_reg;
  assign mac_a   = a_data;
  assign mac_b   = b_data;
  assign c_valid = (state_reg == S_WRITE);
  assign c_data  = c_valid ? mac_out : 16'd0;

  // Row-major addressing for all three matrices.
  assign a_addr = AW'(i_reg) * DIM_A + AW'(k_reg);
  assign b_addr = AW'(k_reg) * DIM_A + AW'(j_reg);
  assign c_addr = AW'(i_reg) * DIM_A + AW'(j_reg);

`ifdef MMUL_SEQ_OVF_EN
  logic [15:0] prev_reg;
  logic        mac_en_d_reg;
  logic        ovf_reg;

  // Unsigned products make the accumulator monotonic, so any decrease means it wrapped.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_reg     <= 16'd0;
      mac_en_d_reg <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      mac_en_d_reg <= mac_en_reg;
      if (mac_clr) begin
        prev_reg <= 16'd0;
      end else if (mac_en_d_reg) begin
        prev_reg <= mac_out;
      end
      if (state_reg == S_IDLE && start) begin
        ovf_reg <= 1'b0;
      end else if (mac_en_d_reg && (mac_out < prev_reg)) begin
        ovf_reg <= 1'b1;
      end
    end
  end

  assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_mmul_seq_ctrl.sv
// Bench for mmul_seq_ctrl: DIM=2 and DIM=4 instances with behavioural memories and MAC,
// results checked against a plain matrix-product reference model.
module tb_mmul_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  logic [7:0] a2_mem [64];
  logic [7:0] b2_mem [64];
  logic [7:0] a4_mem [64];
  logic [7:0] b4_mem [64];
  int         exp_c  [64];

  // DIM=2 instance signals
  logic        reset2 = 1'b1, start2 = 1'b0, ready2 = 1'b1;
  logic        busy2, done2, mac_clr2, mac_en2, c_valid2;
  logic [5:0]  a_addr2, b_addr2, c_addr2;
  logic [7:0]  a_q2, b_q2, mac_a2, mac_b2;
  logic [15:0] acc2 = 16'd0, c_data2;
  // DIM=4 instance signals
  logic        reset4 = 1'b1, start4 = 1'b0, ready4 = 1'b1;
  logic        busy4, done4, mac_clr4, mac_en4, c_valid4;
  logic [5:0]  a_addr4, b_addr4, c_addr4;
  logic [7:0]  a_q4, b_q4, mac_a4, mac_b4;
  logic [15:0] acc4 = 16'd0, c_data4;
`ifdef MMUL_SEQ_OVF_EN
  logic        ovf2, ovf4;
`endif

  mmul_seq_ctrl #(.DIM(2), .AW(6)) dut2 (
    .clk(clk), .reset(reset2), .start(start2), .busy(busy2), .done(done2),
    .a_addr(a_addr2), .b_addr(b_addr2), .a_data(a_q2), .b_data(b_q2),
    .mac_clr(mac_clr2), .mac_en(mac_en2), .mac_a(mac_a2), .mac_b(mac_b2),
    .mac_out(acc2), .c_addr(c_addr2), .c_data(c_data2), .c_valid(c_valid2),
    .c_ready(ready2)
`ifdef MMUL_SEQ_OVF_EN
    , .ovf(ovf2)
`endif
  );

  mmul_seq_ctrl #(.DIM(4), .AW(6)) dut4 (
    .clk(clk), .reset(reset4), .start(start4), .busy(busy4), .done(done4),
    .a_addr(a_addr4), .b_addr(b_addr4), .a_data(a_q4), .b_data(b_q4),
    .mac_clr(mac_clr4), .mac_en(mac_en4), .mac_a(mac_a4), .mac_b(mac_b4),
    .mac_out(acc4), .c_addr(c_addr4), .c_data(c_data4), .c_valid(c_valid4),
    .c_ready(ready4)
`ifdef MMUL_SEQ_OVF_EN
    , .ovf(ovf4)
`endif
  );

  // Synchronous operand memories and the shared MAC (environment models).
  always @(posedge clk) begin
    a_q2 <= a2_mem[a_addr2];
    b_q2 <= b2_mem[b_addr2];
    a_q4 <= a4_mem[a_addr4];
    b_q4 <= b4_mem[b_addr4];
    if (mac_clr2) acc2 <= 16'd0;
    else if (mac_en2) acc2 <= acc2 + {8'd0, mac_a2} * {8'd0, mac_b2};
    if (mac_clr4) acc4 <= 16'd0;
    else if (mac_en4) acc4 <= acc4 + {8'd0, mac_a4} * {8'd0, mac_b4};
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j] mod 2^16, row-major.
  task automatic model(input int d, input bit big);
    for (int i = 0; i < d; i++) begin
      for (int j = 0; j < d; j++) begin
        int s = 0;
        for (int k = 0; k < d; k++) begin
          if (big) s += int'(a4_mem[i*d+k]) * int'(b4_mem[k*d+j]);
          else     s += int'(a2_mem[i*d+k]) * int'(b2_mem[k*d+j]);
        end
        exp_c[i*d+j] = s % 65536;
      end
    end
  endtask

  // mode 0: always ready; 1: ready low in cycles 5..7; 2: random ready.
  task automatic run2(input int mode, input bit pulses, input int abort_at);
    int n = 0;
    int stalls = 0;
    bit seen = 1'b0;
    bit fin = 1'b0;
    start2 = 1'b1;
    cyc = 0;
    while (!fin && cyc < 400) begin
      tick();
      start2 = pulses && (cyc == 3 || cyc == 12);
      reset2 = (cyc == abort_at);
      case (mode)
        0:       ready2 = 1'b1;
        1:       ready2 = !(cyc >= 5 && cyc <= 7);
        default: ready2 = ($urandom_range(0, 2) != 0);
      endcase
      if (abort_at >= 0 && cyc == abort_at + 1) begin
        chk("abort_busy", busy2, 0);
        chk("abort_c_valid", c_valid2, 0);
        chk("abort_mac_en", mac_en2, 0);
        chk("abort_c_data", c_data2, 0);
        chk("abort_done", done2, 0);
        repeat (3) begin
          tick();
          chk("abort_no_done", done2, 0);
        end
        fin = 1'b1;
      end else begin
        if (cyc == 1) begin
          chk("busy_cycle1", busy2, 1);
          chk("mac_clr_cycle1", mac_clr2, 1);
`ifdef MMUL_SEQ_OVF_EN
          chk("ovf_cleared_by_start", ovf2, 0);
`endif
        end
        if (c_valid2) begin
          if (!seen) begin
            chk("write_arrival_cycle", cyc, 5 * (n + 1) + stalls);
            seen = 1'b1;
          end
          chk("c_addr", c_addr2, n);
          chk("c_data", c_data2, exp_c[n]);
          if (ready2) begin
            $display("dim2 write addr=%0d data=%0d cycle=%0d", c_addr2, c_data2, cyc);
            n++;
            seen = 1'b0;
          end else begin
            stalls++;
          end
        end
        if (done2) begin
          chk("done_count", n, 4);
          chk("done_cycle", cyc, 4 * 5 + 1 + stalls);
          tick();
          chk("idle_busy", busy2, 0);
          chk("idle_done", done2, 0);
          fin = 1'b1;
        end
      end
    end
    chk("run2_finished", fin, 1);
  endtask

  task automatic run4();
    int n = 0;
    bit fin = 1'b0;
    start4 = 1'b1;
    cyc = 0;
    while (!fin && cyc < 400) begin
      tick();
      start4 = 1'b0;
      if (c_valid4) begin
        chk("d4_arrival_cycle", cyc, 7 * (n + 1));
        chk("d4_c_addr", c_addr4, n);
        chk("d4_c_data", c_data4, exp_c[n]);
        $display("dim4 write addr=%0d data=%0d cycle=%0d", c_addr4, c_data4, cyc);
        n++;
      end
      if (done4) begin
        chk("d4_done_cycle", cyc, 113);
        chk("d4_done_count", n, 16);
        tick();
        chk("d4_idle_busy", busy4, 0);
        fin = 1'b1;
      end
    end
    chk("run4_finished", fin, 1);
  endtask

  initial begin
    repeat (3) tick();
    reset2 = 1'b0;
    reset4 = 1'b0;
    tick();
    chk("rst_busy", busy2, 0);
    chk("rst_done", done2, 0);
    chk("rst_mac_clr", mac_clr2, 0);
    chk("rst_mac_en", mac_en2, 0);
    chk("rst_c_valid", c_valid2, 0);
    chk("rst_a_addr", a_addr2, 0);
    chk("rst_b_addr", b_addr2, 0);
    chk("rst_c_addr", c_addr2, 0);
    chk("rst_c_data", c_data2, 0);
`ifdef MMUL_SEQ_OVF_EN
    chk("rst_ovf", ovf2, 0);
`endif

    a2_mem[0] = 8'd1; a2_mem[1] = 8'd2; a2_mem[2] = 8'd3; a2_mem[3] = 8'd4;
    b2_mem[0] = 8'd4; b2_mem[1] = 8'd5; b2_mem[2] = 8'd6; b2_mem[3] = 8'd7;
    model(2, 1'b0);
    run2(0, 1'b0, -1);
    run2(1, 1'b0, -1);
    run2(0, 1'b0, 7);
    run2(0, 1'b0, -1);
    run2(0, 1'b1, -1);
    run2(0, 1'b0, -1);

    for (int x = 0; x < 4; x++) begin
      a2_mem[x] = 8'd255;
      b2_mem[x] = 8'd255;
    end
    model(2, 1'b0);
    run2(0, 1'b0, -1);
`ifdef MMUL_SEQ_OVF_EN
    chk("ovf_sticky", ovf2, 1);
`endif

    for (int r = 0; r < 6; r++) begin
      for (int x = 0; x < 4; x++) begin
        a2_mem[x] = 8'($urandom);
        b2_mem[x] = 8'($urandom);
      end
      model(2, 1'b0);
      run2(2, 1'b0, -1);
    end

    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        a4_mem[r*4+c] = (r == c) ? 8'd1 : 8'd0;
        b4_mem[r*4+c] = 8'(r * 4 + c);
      end
    end
    model(4, 1'b1);
    run4();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
